// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
//
// Shared definitions for the next-PC sequencer:
//   - opcode / funct values of the control-flow instructions it recognises
//   - save/restore codes driven on the PC's sr port
//   - FSM state encoding and the instruction-class enum
//   - classify(): maps opcode/funct/rs onto an instruction class
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    // Opcode and funct fields of the instructions that alter control flow
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] FN_JR    = 6'd8;

    // Save/restore codes understood by the PC (code 2 is never used)
    localparam logic [1:0] SR_NONE    = 2'd0;
    localparam logic [1:0] SR_SAVE    = 2'd1;
    localparam logic [1:0] SR_RESTORE = 2'd3;

    // The encoding is visible on the state port, so the values are fixed
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CL_SEQ = 3'd0,
        CL_BEQ = 3'd1,
        CL_BNE = 3'd2,
        CL_J   = 3'd3,
        CL_JAL = 3'd4,
        CL_JR  = 3'd5,
        CL_RET = 3'd6
    } instr_class_e;

    // Anything that is not a recognised control-flow instruction falls
    // through sequentially. A jr through the return-address register is a
    // return and gets its own class so UPDATE can restore the link.
    function automatic instr_class_e classify(
        input logic [5:0] op,
        input logic [5:0] fn,
        input logic [4:0] rs,
        input logic [4:0] ra
    );
        instr_class_e cls;
        cls = CL_SEQ;
        case (op)
            OP_BEQ:   cls = CL_BEQ;
            OP_BNE:   cls = CL_BNE;
            OP_J:     cls = CL_J;
            OP_JAL:   cls = CL_JAL;
            OP_RTYPE: begin
                if (fn == FN_JR) begin
                    cls = (rs == ra) ? CL_RET : CL_JR;
                end
            end
            default:  cls = CL_SEQ;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
//
// Purely combinational candidate next-address generator. All sums wrap
// modulo 2^32.
//
// Ports:
//   pc_in    in  32  current PC
//   imm      in  16  branch offset in words (signed)
//   target   in  26  jump target in words
//   seq_addr out 32  pc_in + 4
//   br_addr  out 32  pc_in + 4 + sign_ext(imm) * 4
//   jmp_addr out 32  {seq_addr[31:28], target, 2'b00}
// -----------------------------------------------------------------------------
module pc_target_calc (
    input  logic [31:0] pc_in,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] seq_addr,
    output logic [31:0] br_addr,
    output logic [31:0] jmp_addr
);

    // Branch and jump targets are both relative to the sequential address:
    // branches add a word offset, jumps keep its top nibble as the region
    assign seq_addr = pc_in + 32'd4;
    assign br_addr  = seq_addr + {{14{imm[15]}}, imm, 2'b00};
    assign jmp_addr = {seq_addr[31:28], target, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Multi-cycle next-PC controller. Walks each instruction through
// FETCH -> DECODE -> EXEC -> UPDATE and drives the PC's en/sr/address
// interface. Every output is registered, so each strobe becomes visible the
// cycle after the state that decides it: ir_write shows in DECODE and the
// pc_en / pc_sr pulse shows in the FETCH cycle following UPDATE.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   hold     in   1  freezes every register while high
//   instr    in  32  instruction word, valid from DECODE onward
//   pc_in    in  32  current PC value
//   rs_data  in  32  register-file rs read data, valid in EXEC
//   zero     in   1  ALU zero flag, valid in EXEC
//   pc_en    out  1  PC load enable pulse
//   pc_sr    out  2  0 none, 1 save pc_in+4 as link, 3 restore link
//   pc_next  out 32  address loaded by the PC when pc_en=1
//   ir_write out  1  instruction register load strobe
//   state    out  2  0 FETCH, 1 DECODE, 2 EXEC, 3 UPDATE
//   call_ovf out  1  sticky: jal issued while a link was already live
//   ret_unf  out  1  sticky: return issued with no live link
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int FETCH_WAIT = 1,
    parameter int RA_REG     = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic [31:0] rs_data,
    input  logic        zero,
    output logic        pc_en,
    output logic [1:0]  pc_sr,
    output logic [31:0] pc_next,
    output logic        ir_write,
    output logic [1:0]  state,
    output logic        call_ovf,
    output logic        ret_unf
);

    import pc_sequencer_pkg::*;

    localparam int               CNT_W    = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_WAIT - 1);
    localparam logic [4:0]       RA_SEL   = 5'(RA_REG);

    state_e       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic         ir_write_q, ir_write_d;
    logic         pc_en_q,    pc_en_d;
    logic [1:0]   pc_sr_q,    pc_sr_d;
    logic [31:0]  pc_next_q,  pc_next_d;
    logic         depth_q,    depth_d;
    logic         call_ovf_q, call_ovf_d;
    logic         ret_unf_q,  ret_unf_d;
    instr_class_e class_q,    class_d;
    logic [15:0]  imm_q,      imm_d;
    logic [25:0]  target_q,   target_d;
    logic [31:0]  addr_q,     addr_d;

    logic [31:0]  seq_addr;
    logic [31:0]  br_addr;
    logic [31:0]  jmp_addr;

    // Candidate addresses are formed from the latched immediate/target and
    // the live pc_in, so they are only meaningful while in EXEC
    pc_target_calc u_target_calc (
        .pc_in    (pc_in),
        .imm      (imm_q),
        .target   (target_q),
        .seq_addr (seq_addr),
        .br_addr  (br_addr),
        .jmp_addr (jmp_addr)
    );

    // Next-state and next-output logic. Every register defaults to its
    // current value so that hold simply skips all updates, strobes
    // included. When not holding, the pulse outputs fall back to zero
    // unless the current state asks for them; pc_next keeps its last value.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ir_write_d = ir_write_q;
        pc_en_d    = pc_en_q;
        pc_sr_d    = pc_sr_q;
        pc_next_d  = pc_next_q;
        depth_d    = depth_q;
        call_ovf_d = call_ovf_q;
        ret_unf_d  = ret_unf_q;
        class_d    = class_q;
        imm_d      = imm_q;
        target_d   = target_q;
        addr_d     = addr_q;

        if (!hold) begin
            ir_write_d = 1'b0;
            pc_en_d    = 1'b0;
            pc_sr_d    = SR_NONE;

            case (state_q)
                // Wait out the instruction memory latency, then strobe the IR
                ST_FETCH: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        ir_write_d = 1'b1;
                        state_d    = ST_DECODE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                // Only the class, immediate and target survive decode;
                // opcode, funct and rs are consumed by the classifier
                ST_DECODE: begin
                    class_d  = classify(instr[31:26], instr[5:0], instr[25:21], RA_SEL);
                    imm_d    = instr[15:0];
                    target_d = instr[25:0];
                    state_d  = ST_EXEC;
                end

                // Resolve the address now, while zero and rs_data are valid.
                // A return resolves to the sequential address, which is what
                // an underflowing return falls back to.
                ST_EXEC: begin
                    case (class_q)
                        CL_BEQ:       addr_d = zero ? br_addr : seq_addr;
                        CL_BNE:       addr_d = zero ? seq_addr : br_addr;
                        CL_J, CL_JAL: addr_d = jmp_addr;
                        CL_JR:        addr_d = rs_data;
                        default:      addr_d = seq_addr;
                    endcase
                    state_d = ST_EXEC == state_q ? ST_UPDATE : state_q;
                end

                // Issue the PC update. A call always saves and marks the link
                // live; a return with a live link restores it instead of
                // loading an address, and one without degrades to sequential.
                ST_UPDATE: begin
                    case (class_q)
                        CL_JAL: begin
                            pc_en_d   = 1'b1;
                            pc_sr_d   = SR_SAVE;
                            pc_next_d = addr_q;
                            if (depth_q) begin
                                call_ovf_d = 1'b1;
                            end
                            depth_d = 1'b1;
                        end
                        CL_RET: begin
                            if (depth_q) begin
                                pc_sr_d   = SR_RESTORE;
                                pc_next_d = '0;
                                depth_d   = 1'b0;
                            end else begin
                                pc_en_d   = 1'b1;
                                pc_next_d = addr_q;
                                ret_unf_d = 1'b1;
                            end
                        end
                        default: begin
                            pc_en_d   = 1'b1;
                            pc_next_d = addr_q;
                        end
                    endcase
                    state_d = ST_FETCH;
                end

                default: state_d = ST_FETCH;
            endcase
        end
    end

    // State and output registers. Reset is asynchronous so an instruction
    // in flight is abandoned at once and no update reaches the PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            cnt_q      <= '0;
            ir_write_q <= 1'b0;
            pc_en_q    <= 1'b0;
            pc_sr_q    <= SR_NONE;
            pc_next_q  <= '0;
            depth_q    <= 1'b0;
            call_ovf_q <= 1'b0;
            ret_unf_q  <= 1'b0;
            class_q    <= CL_SEQ;
            imm_q      <= '0;
            target_q   <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ir_write_q <= ir_write_d;
            pc_en_q    <= pc_en_d;
            pc_sr_q    <= pc_sr_d;
            pc_next_q  <= pc_next_d;
            depth_q    <= depth_d;
            call_ovf_q <= call_ovf_d;
            ret_unf_q  <= ret_unf_d;
            class_q    <= class_d;
            imm_q      <= imm_d;
            target_q   <= target_d;
            addr_q     <= addr_d;
        end
    end

    assign pc_en    = pc_en_q;
    assign pc_sr    = pc_sr_q;
    assign pc_next  = pc_next_q;
    assign ir_write = ir_write_q;
    assign state    = state_q;
    assign call_ovf = call_ovf_q;
    assign ret_unf  = ret_unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Drives directed and random instructions into pc_sequencer and compares all
// outputs every cycle against an instruction-level model: each instruction
// takes FW+3 non-held cycles, ir_write appears FW cycles in, and the effect
// of the instruction appears as a pulse at the start of the next one.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int FW = 1;
    localparam int L  = FW + 3;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic [31:0] rs_data;
    logic        zero;
    logic        pc_en;
    logic [1:0]  pc_sr;
    logic [31:0] pc_next;
    logic        ir_write;
    logic [1:0]  state;
    logic        call_ovf;
    logic        ret_unf;

    int checks = 0;
    int errors = 0;
    bit holdRand = 0;

    // Model state: position within the current instruction plus the values
    // every output must show
    int          pos;
    logic        mEn;
    logic [1:0]  mSr;
    logic [31:0] mNext;
    logic        mIrw;
    logic        mDepth;
    logic        mOvf;
    logic        mUnf;

    pc_sequencer #(.FETCH_WAIT(FW), .RA_REG(31)) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .instr    (instr),
        .pc_in    (pc_in),
        .rs_data  (rs_data),
        .zero     (zero),
        .pc_en    (pc_en),
        .pc_sr    (pc_sr),
        .pc_next  (pc_next),
        .ir_write (ir_write),
        .state    (state),
        .call_ovf (call_ovf),
        .ret_unf  (ret_unf)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expState(input int p);
        return (p < FW) ? 32'd0 : 32'(p - FW + 1);
    endfunction

    task automatic modelReset();
        pos = 0; mEn = 0; mSr = 0; mNext = 0; mIrw = 0;
        mDepth = 0; mOvf = 0; mUnf = 0;
    endtask

    // Effect of the current instruction, computed straight from its fields
    task automatic applyEffect();
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] seq;
        logic [31:0] br;
        logic [31:0] jmp;
        op  = instr[31:26];
        fn  = instr[5:0];
        rs  = instr[25:21];
        imm = instr[15:0];
        tgt = instr[25:0];
        seq = pc_in + 32'd4;
        br  = seq + ({{16{imm[15]}}, imm} * 32'd4);
        jmp = {seq[31:28], tgt, 2'b00};
        mEn = 1; mSr = 0;
        if (op == 6'd4) begin
            mNext = zero ? br : seq;
        end else if (op == 6'd5) begin
            mNext = zero ? seq : br;
        end else if (op == 6'd2) begin
            mNext = jmp;
        end else if (op == 6'd3) begin
            if (mDepth) mOvf = 1;
            mDepth = 1; mSr = 1; mNext = jmp;
        end else if (op == 6'd0 && fn == 6'd8 && rs == 5'd31) begin
            if (mDepth) begin
                mEn = 0; mSr = 3; mNext = 0; mDepth = 0;
            end else begin
                mNext = seq; mUnf = 1;
            end
        end else if (op == 6'd0 && fn == 6'd8) begin
            mNext = rs_data;
        end else begin
            mNext = seq;
        end
    endtask

    task automatic modelEdge();
        if (hold) return;
        mEn = 0; mSr = 0; mIrw = 0;
        if (pos == FW - 1) mIrw = 1;
        if (pos == L - 1) applyEffect();
        pos = (pos + 1) % L;
    endtask

    task automatic compareAll();
        checkOutput("pc_en",    32'(pc_en),    32'(mEn));
        checkOutput("pc_sr",    32'(pc_sr),    32'(mSr));
        checkOutput("pc_next",  pc_next,       mNext);
        checkOutput("ir_write", 32'(ir_write), 32'(mIrw));
        checkOutput("state",    32'(state),    expState(pos));
        checkOutput("call_ovf", 32'(call_ovf), 32'(mOvf));
        checkOutput("ret_unf",  32'(ret_unf),  32'(mUnf));
    endtask

    // One clock: optionally randomise hold, advance the model at the edge,
    // then compare just after it
    task automatic tick();
        if (holdRand) hold = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        if (rst) modelReset();
        else modelEdge();
        #1;
        compareAll();
    endtask

    task automatic runToBoundary();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (pos != 0 && n < 1000);
        if (pos != 0) begin
            errors++;
            $display("[TB] FAIL boundary_timeout actual=%0d expected=0", pos);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] iw, input logic [31:0] pc,
                                 input logic [31:0] rsd, input logic z);
        instr = iw; pc_in = pc; rs_data = rsd; zero = z;
        runToBoundary();
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        r = $urandom();
        case ($urandom_range(0, 7))
            0: begin
                op = 6'($urandom_range(6, 63));
                return {op, r[25:0]};
            end
            1: return {6'd4, r[25:0]};
            2: return {6'd5, r[25:0]};
            3: return {6'd2, r[25:0]};
            4: return {6'd3, r[25:0]};
            5: return {6'd0, r[25:21], r[20:6], 6'd8};
            6: return {6'd0, 5'd31, r[20:6], 6'd8};
            default: begin
                fn = r[5:0];
                if (fn == 6'd8) fn = 6'd32;
                return {6'd0, r[25:6], fn};
            end
        endcase
    endfunction

    initial begin
        rst = 1; hold = 0; instr = 0; pc_in = 0; rs_data = 0; zero = 0;
        modelReset();
        tick();
        tick();
        checkOutput("lit_reset_state", 32'(state), 32'd0);
        checkOutput("lit_reset_next", pc_next, 32'd0);
        rst = 0;

        // SEQ at 240: ir_write in cycle 1, pulse in cycle 4
        instr = 32'h0000_0020; pc_in = 32'd240; rs_data = 0; zero = 0;
        tick();
        checkOutput("lit_irw_cycle1", 32'(ir_write), 32'd1);
        runToBoundary();
        checkOutput("lit_seq_en", 32'(pc_en), 32'd1);
        checkOutput("lit_seq_next", pc_next, 32'd244);
        checkOutput("lit_seq_sr", 32'(pc_sr), 32'd0);

        // Branches with a backward offset of two words
        applyStimulus({6'd4, 5'd1, 5'd2, 16'hFFFE}, 32'h100, 0, 1);
        checkOutput("lit_beq_taken", pc_next, 32'h0FC);
        applyStimulus({6'd4, 5'd1, 5'd2, 16'hFFFE}, 32'h100, 0, 0);
        checkOutput("lit_beq_not", pc_next, 32'h104);
        applyStimulus({6'd5, 5'd1, 5'd2, 16'hFFFE}, 32'h100, 0, 1);
        checkOutput("lit_bne_not", pc_next, 32'h104);
        applyStimulus({6'd5, 5'd1, 5'd2, 16'hFFFE}, 32'h100, 0, 0);
        checkOutput("lit_bne_taken", pc_next, 32'h0FC);

        // Call then return
        applyStimulus({6'd3, 26'h40}, 32'h1000_00F0, 0, 0);
        checkOutput("lit_jal_next", pc_next, 32'h1000_0100);
        checkOutput("lit_jal_sr", 32'(pc_sr), 32'd1);
        checkOutput("lit_jal_en", 32'(pc_en), 32'd1);
        applyStimulus({6'd0, 5'd31, 15'd0, 6'd8}, 32'h1000_0100, 32'h1234, 0);
        checkOutput("lit_ret_sr", 32'(pc_sr), 32'd3);
        checkOutput("lit_ret_en", 32'(pc_en), 32'd0);

        // Two calls overflow; a return then drains, a second underflows
        applyStimulus({6'd3, 26'h80}, 32'h300, 0, 0);
        applyStimulus({6'd3, 26'h90}, 32'h200, 0, 0);
        checkOutput("lit_call_ovf", 32'(call_ovf), 32'd1);
        applyStimulus({6'd0, 5'd31, 15'd0, 6'd8}, 32'h240, 0, 0);
        applyStimulus({6'd0, 5'd31, 15'd0, 6'd8}, 32'h500, 0, 0);
        checkOutput("lit_unf_next", pc_next, 32'h504);
        checkOutput("lit_ret_unf", 32'(ret_unf), 32'd1);

        // Wrap-around and register jump
        applyStimulus(32'h0000_0020, 32'hFFFF_FFFC, 0, 0);
        checkOutput("lit_wrap", pc_next, 32'h0);
        applyStimulus({6'd0, 5'd5, 15'd0, 6'd8}, 32'h40, 32'h200, 0);
        checkOutput("lit_jr_next", pc_next, 32'h200);
        checkOutput("lit_jr_sr", 32'(pc_sr), 32'd0);

        // hold while the pulse is showing keeps it and the state frozen
        applyStimulus(32'h0000_0020, 32'h10, 0, 0);
        hold = 1;
        repeat (3) tick();
        checkOutput("lit_hold_en", 32'(pc_en), 32'd1);
        checkOutput("lit_hold_state", 32'(state), 32'd0);
        hold = 0;

        // Asynchronous reset while in EXEC abandons the call
        instr = {6'd3, 26'h55}; pc_in = 32'h800; zero = 0;
        repeat (FW + 1) tick();
        checkOutput("lit_pre_rst_state", 32'(state), 32'd2);
        #2;
        rst = 1;
        #1;
        checkOutput("lit_arst_state", 32'(state), 32'd0);
        checkOutput("lit_arst_ovf", 32'(call_ovf), 32'd0);
        checkOutput("lit_arst_unf", 32'(ret_unf), 32'd0);
        checkOutput("lit_arst_next", pc_next, 32'd0);
        modelReset();
        tick();
        rst = 0;
        applyStimulus({6'd0, 5'd31, 15'd0, 6'd8}, 32'h700, 0, 0);
        checkOutput("lit_post_rst_unf", 32'(ret_unf), 32'd1);
        checkOutput("lit_post_rst_en", 32'(pc_en), 32'd1);

        // Random instructions with random hold
        holdRand = 1;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(randInstr(), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
        end
        holdRand = 0;
        hold = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle next-PC controller that drives the program counter's en / sr / address interface, i.e. the initiating side of the PC update protocol.
- Sequences fetch → decode → execute → update per instruction.
- Computes the next address for sequential, branch (beq/bne), jump (j), call (jal) and register-jump (jr) instructions.
- Issues save-link (sr=1) on calls and restore-link (sr=3) on returns, and tracks the single-level link depth.

Parameters:
- FETCH_WAIT, 1, number of cycles spent in FETCH before ir_write pulses (instruction memory latency, ≥1).
- RA_REG, 31, register number whose jr is treated as a return (restore-link).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- hold  input  1  freezes FSM and all registered outputs while high.
- instr  input  32  instruction word, valid from the DECODE cycle onward.
- pc_in  input  32  current PC value (the PC's pcout).
- rs_data  input  32  register-file rs read data, valid in EXEC.
- zero  input  1  ALU zero flag, valid in EXEC.
- pc_en  output  1  PC load enable, one-cycle pulse.
- pc_sr  output  2  save/restore code: 0 none, 1 save pc_in+4 as link, 3 restore link; 2 never driven.
- pc_next  output  32  address loaded by the PC when pc_en=1.
- ir_write  output  1  instruction register load strobe.
- state  output  2  FSM state: 0 FETCH, 1 DECODE, 2 EXEC, 3 UPDATE.
- call_ovf  output  1  sticky: jal issued while depth already 1.
- ret_unf  output  1  sticky: return issued while depth 0.

Behaviour:
- Reset (async, immediate): state=FETCH, fetch counter=0, pc_en=0, pc_sr=0, pc_next=0, ir_write=0, depth=0, call_ovf=0, ret_unf=0.
- All outputs are registered. rst overrides hold. hold=1 holds every register unchanged, including strobe outputs.
- FETCH:
  - The counter counts 0..FETCH_WAIT-1.
  - On the last count, ir_write=1 for exactly one cycle and the FSM moves to DECODE.
- DECODE:
  - Latch opcode instr[31:26], funct instr[5:0], rs instr[25:21], imm instr[15:0], target instr[25:0].
  - Classify: SEQ, BEQ(op 4), BNE(op 5), J(op 2), JAL(op 3), JR(op 0 & funct 8), RET(JR with rs==RA_REG).
  - Move to EXEC.
- EXEC: sample zero and rs_data, compute next address, move to UPDATE. Arithmetic is 32-bit modulo (wrap-around at 2^32):
  - seq = pc_in+4.
  - br = pc_in+4+(sign_ext(imm)<<2).
  - jmp = {seq[31:28], target, 2'b00}.
- UPDATE: one-cycle pulse, then return to FETCH.
  - SEQ: pc_en=1, pc_sr=0, pc_next=seq.
  - BEQ: pc_next = zero ? br : seq.
  - BNE: pc_next = zero ? seq : br.
  - In both branch cases pc_en=1, pc_sr=0.
  - J: pc_en=1, pc_next=jmp, pc_sr=0.
  - JAL: pc_en=1, pc_sr=1, pc_next=jmp. The link saved is the old pc_in+4. If depth==1, set call_ovf (call still issued, link overwritten). depth←1.
  - JR (non-RA): pc_en=1, pc_sr=0, pc_next=rs_data.
  - RET, depth==1: pc_sr=3, pc_en=0, pc_next=0. depth←0.
  - RET, depth==0: treated as SEQ and sets ret_unf.
- Outside UPDATE: pc_en=0 and pc_sr=0. pc_next holds its last value.
- Latency:
  - FETCH_WAIT+3 cycles per instruction.
  - The PC changes at the clock edge following the UPDATE cycle's output.
- Reset mid-instruction abandons the instruction; no pc_en or pc_sr is emitted.

Decomposition:
- Shared package holds:
  - Opcode/funct constants: OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_BEQ=4, OP_BNE=5, FN_JR=8.
  - SR code constants: SR_NONE=0, SR_SAVE=1, SR_RESTORE=3.
  - The state encoding and the instruction-class enum.
- One natural sub-module: pc_target_calc. It is combinational and produces seq/br/jmp from pc_in, imm and target.

Test Plan:
- Reset then SEQ, pc_in=240, FETCH_WAIT=1 → ir_write at cycle 1, pc_en pulse in cycle 4, pc_next=244, pc_sr=0.
- BEQ imm=0xFFFE, pc_in=0x100: with zero=1 → pc_next=0xFC; with zero=0 → 0x104. BNE gives the inverse.
- JAL target=0x40, pc_in=0x1000_00F0 → pc_next=0x1000_0100, pc_sr=1 with pc_en=1, depth=1. A following jr $31 → pc_sr=3, pc_en=0, depth=0.
- Two JALs without a return → call_ovf=1 after the second. A return at depth 0 → pc_next=pc_in+4, ret_unf=1.
- Wrap-around: SEQ at pc_in=0xFFFF_FFFC → pc_next=0. jr $5 with rs_data=0x200 → pc_next=0x200, pc_sr=0.
- hold high during UPDATE → pc_en stays high, state frozen. Async rst asserted in EXEC → outputs zero immediately, state=FETCH, no update emitted.
